erx_fifo_array: RTL

- Single-clock, N-channel receive buffer for the elink RX path. It is the parametrised successor to the fixed three-channel (rd/wr/rr) RX FIFO set.
- Each channel is an independent first-word-fall-through FIFO with emesh access/wait handshakes on both sides.
- Each channel has a programmable almost-full threshold that drives back-pressure, a sticky overflow flag and a live occupancy count.
- Sits between the RX protocol decoder and the AXI master/slave ports once both run in one clock domain.

---
 rtl/erx_fifo_array_pkg.sv | 19 +
 rtl/erx_fifo_chan.sv | 96 +++++++++
 rtl/erx_fifo_array.sv | 53 +++++
 3 files changed

// File: rtl/erx_fifo_array_pkg.sv
// ============================================================================
// Module : erx_fifo_array_pkg
// Brief  : Shared defaults and channel index constants for the RX FIFO array.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package erx_fifo_array_pkg;
    localparam int DEF_PW       = 104;
    localparam int DEF_CH       = 3;
    localparam int DEF_DEPTH    = 32;
    localparam int AFULL_MARGIN = 4;

    localparam int RXRD = 0;
    localparam int RXWR = 1;
    localparam int RXRR = 2;
endpackage

`default_nettype wire

// File: rtl/erx_fifo_chan.sv
// ============================================================================
// Module : erx_fifo_chan
// Brief  : One first-word-fall-through FIFO channel with count, wait, overflow.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module erx_fifo_chan
    import erx_fifo_array_pkg::*;
#(
    parameter int PW    = DEF_PW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AFULL = DEPTH - AFULL_MARGIN,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          access_in,
    input  logic [PW-1:0] packet_in,
    output logic          wait_out,
    output logic          access_out,
    output logic [PW-1:0] packet_out,
    input  logic          wait_in,
    output logic          overflow,
    input  logic          overflow_clr,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [PW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] w_rd_ptr_nxt;
    logic          w_pop;
    logic          w_push;
    logic          w_full;
    logic          w_drop;
    logic [CW-1:0] w_count_after_pop;
    logic [CW-1:0] w_count_nxt;

    assign w_pop             = access_out & ~wait_in;
    assign w_full            = (count == CW'(DEPTH));
    assign w_push            = access_in & (~w_full | w_pop);
    assign w_drop            = access_in & w_full & ~w_pop;
    assign w_rd_ptr_nxt      = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
    assign w_count_after_pop = count - CW'(w_pop);
    assign w_count_nxt       = w_count_after_pop + CW'(w_push);

    // Memory holds every stored word, head included; the head register is a copy
    // so a push-at-full may overwrite the slot being popped in the same cycle.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= packet_in;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            count      <= '0;
            wait_out   <= 1'b0;
            overflow   <= 1'b0;
            access_out <= 1'b0;
            packet_out <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            count    <= w_count_nxt;
            wait_out <= (w_count_nxt >= CW'(AFULL));

            if (w_drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end

            // Reload the head when it is consumed or empty; bypass the input
            // when no older word remains behind the popped head.
            if (w_pop || !access_out) begin
                if (w_count_nxt == '0) begin
                    access_out <= 1'b0;
                end else begin
                    access_out <= 1'b1;
                    packet_out <= (w_count_after_pop != '0) ? r_mem[w_rd_ptr_nxt] : packet_in;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/erx_fifo_array.sv
// ============================================================================
// Module : erx_fifo_array
// Brief  : N independent FWFT receive FIFOs for the elink RX path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module erx_fifo_array
    import erx_fifo_array_pkg::*;
#(
    parameter int PW    = DEF_PW,
    parameter int CH    = DEF_CH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AFULL = DEPTH - AFULL_MARGIN,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [CH-1:0]    access_in,
    input  logic [CH*PW-1:0] packet_in,
    output logic [CH-1:0]    wait_out,
    output logic [CH-1:0]    access_out,
    output logic [CH*PW-1:0] packet_out,
    input  logic [CH-1:0]    wait_in,
    output logic [CH-1:0]    overflow,
    input  logic [CH-1:0]    overflow_clr,
    output logic [CH*CW-1:0] count
);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        erx_fifo_chan #(
            .PW    (PW),
            .DEPTH (DEPTH),
            .AFULL (AFULL),
            .CW    (CW)
        ) u_chan (
            .clk          (clk),
            .nreset       (nreset),
            .access_in    (access_in[i]),
            .packet_in    (packet_in[i*PW +: PW]),
            .wait_out     (wait_out[i]),
            .access_out   (access_out[i]),
            .packet_out   (packet_out[i*PW +: PW]),
            .wait_in      (wait_in[i]),
            .overflow     (overflow[i]),
            .overflow_clr (overflow_clr[i]),
            .count        (count[i*CW +: CW])
        );
    end

endmodule

`default_nettype wire
